// File: rtl/procyon_types.sv
// ============================================================================
// Module   : procyon_types
// Desc     : Shared tag/data/opcode/address types and CDB sizing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package procyon_types;

    localparam int c_TAG_W     = 6;
    localparam int c_DATA_W    = 32;
    localparam int c_ADDR_W    = 32;
    localparam int c_OPCODE_W  = 5;
    localparam int c_CDB_DEPTH = 2;

    typedef logic [c_TAG_W-1:0]    tag_t;
    typedef logic [c_DATA_W-1:0]   data_t;
    typedef logic [c_ADDR_W-1:0]   addr_t;
    typedef logic [c_OPCODE_W-1:0] opcode_t;

endpackage

`default_nettype wire

// File: rtl/rs_oldest_select.sv
// ============================================================================
// Module   : rs_oldest_select
// Desc     : One-hot grant of the oldest ready, non-excluded slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_oldest_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            i_ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    input  logic [DEPTH-1:0]            i_exclude,
    output logic [DEPTH-1:0]            o_grant
);

    logic [DEPTH-1:0] w_cand;

    assign w_cand = i_ready & ~i_exclude;

    // i_age[j][i] means slot j is older than slot i; a candidate wins if no
    // other candidate is older than it.
    always_comb begin
        o_grant = w_cand;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_cand[j] && i_age[j][i]) begin
                    o_grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reservation_station_mw.sv
// ============================================================================
// Module   : reservation_station_mw
// Desc     : Multi-issue reservation station with CDB wakeup and age ordering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reservation_station_mw
    import procyon_types::*;
#(
    parameter int RS_DEPTH    = 8,
    parameter int NUM_SRC     = 2,
    parameter int CDB_DEPTH   = c_CDB_DEPTH,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_flush,
    input  logic    [CDB_DEPTH-1:0]                i_cdb_en,
    input  data_t   [CDB_DEPTH-1:0]                i_cdb_data,
    input  tag_t    [CDB_DEPTH-1:0]                i_cdb_tag,
    input  logic                                   i_rs_en,
    input  opcode_t                                i_rs_opcode,
    input  addr_t                                  i_rs_iaddr,
    input  data_t                                  i_rs_insn,
    input  tag_t                                   i_rs_dst_tag,
    input  tag_t    [NUM_SRC-1:0]                  i_rs_src_tag,
    input  data_t   [NUM_SRC-1:0]                  i_rs_src_data,
    input  logic    [NUM_SRC-1:0]                  i_rs_src_rdy,
    output logic                                   o_rs_stall,
    input  logic    [ISSUE_WIDTH-1:0]              i_fu_stall,
    output logic    [ISSUE_WIDTH-1:0]              o_fu_valid,
    output opcode_t [ISSUE_WIDTH-1:0]              o_fu_opcode,
    output addr_t   [ISSUE_WIDTH-1:0]              o_fu_iaddr,
    output data_t   [ISSUE_WIDTH-1:0]              o_fu_insn,
    output tag_t    [ISSUE_WIDTH-1:0]              o_fu_tag,
    output data_t   [ISSUE_WIDTH-1:0][NUM_SRC-1:0] o_fu_src
);

    typedef struct packed {
        opcode_t             opcode;
        addr_t               iaddr;
        data_t               insn;
        tag_t                dst_tag;
        tag_t  [NUM_SRC-1:0] src_tag;
        data_t [NUM_SRC-1:0] src_data;
        logic  [NUM_SRC-1:0] src_rdy;
    } rs_slot_t;

    rs_slot_t [RS_DEPTH-1:0]              r_slots;
    rs_slot_t [RS_DEPTH-1:0]              w_slots_nxt;
    rs_slot_t                             w_new;
    logic     [RS_DEPTH-1:0]              r_occupied;
    logic     [RS_DEPTH-1:0][RS_DEPTH-1:0] r_age;
    logic     [RS_DEPTH-1:0]              w_slot_rdy;
    logic     [RS_DEPTH-1:0]              w_lowest_free;
    logic     [RS_DEPTH-1:0]              w_disp_oh;
    logic     [RS_DEPTH-1:0]              w_issued;
    logic                                 w_dispatch;

    logic [ISSUE_WIDTH-1:0]               r_fu_valid;
    opcode_t [ISSUE_WIDTH-1:0]            r_fu_opcode;
    addr_t   [ISSUE_WIDTH-1:0]            r_fu_iaddr;
    data_t   [ISSUE_WIDTH-1:0]            r_fu_insn;
    tag_t    [ISSUE_WIDTH-1:0]            r_fu_tag;
    data_t   [ISSUE_WIDTH-1:0][NUM_SRC-1:0] r_fu_src;

    logic    [ISSUE_WIDTH-1:0]               w_port_free;
    logic    [ISSUE_WIDTH-1:0][RS_DEPTH-1:0] w_take;
    logic    [RS_DEPTH-1:0]                  w_grant0;
    logic    [RS_DEPTH-1:0]                  w_take0;
    opcode_t [ISSUE_WIDTH-1:0]               w_sel_opcode;
    addr_t   [ISSUE_WIDTH-1:0]               w_sel_iaddr;
    data_t   [ISSUE_WIDTH-1:0]               w_sel_insn;
    tag_t    [ISSUE_WIDTH-1:0]               w_sel_tag;
    data_t   [ISSUE_WIDTH-1:0][NUM_SRC-1:0]  w_sel_src;

    assign o_rs_stall    = &r_occupied;
    assign w_dispatch    = i_rs_en & ~o_rs_stall & ~i_flush;
    // Isolate the lowest clear bit of the occupancy vector.
    assign w_lowest_free = ~r_occupied & (r_occupied + {{(RS_DEPTH-1){1'b0}}, 1'b1});
    assign w_disp_oh     = w_lowest_free & {RS_DEPTH{w_dispatch}};

    // Incoming entry with same-cycle CDB bypass; later CDB ports take priority.
    always_comb begin
        w_new.opcode   = i_rs_opcode;
        w_new.iaddr    = i_rs_iaddr;
        w_new.insn     = i_rs_insn;
        w_new.dst_tag  = i_rs_dst_tag;
        w_new.src_tag  = i_rs_src_tag;
        w_new.src_data = i_rs_src_data;
        w_new.src_rdy  = i_rs_src_rdy;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int c = 0; c < CDB_DEPTH; c++) begin
                if (!i_rs_src_rdy[s] && i_cdb_en[c] && (i_cdb_tag[c] == i_rs_src_tag[s])) begin
                    w_new.src_data[s] = i_cdb_data[c];
                    w_new.src_rdy[s]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_slots_nxt = r_slots;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int c = 0; c < CDB_DEPTH; c++) begin
                    if (!r_slots[i].src_rdy[s] && i_cdb_en[c] &&
                        (i_cdb_tag[c] == r_slots[i].src_tag[s])) begin
                        w_slots_nxt[i].src_data[s] = i_cdb_data[c];
                        w_slots_nxt[i].src_rdy[s]  = 1'b1;
                    end
                end
            end
            if (w_disp_oh[i]) begin
                w_slots_nxt[i] = w_new;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_slot_rdy[i] = r_occupied[i] & (&r_slots[i].src_rdy);
        end
    end

    always_ff @(posedge clk) begin
        r_slots <= w_slots_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupied <= '0;
        end else if (i_flush) begin
            r_occupied <= '0;
        end else begin
            r_occupied <= (r_occupied & ~w_issued) | w_disp_oh;
        end
    end

    // New entry is younger than everything resident: clear its row, set its column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (w_disp_oh[i]) begin
                        r_age[i][j] <= 1'b0;
                    end else if (w_disp_oh[j]) begin
                        r_age[i][j] <= r_occupied[i];
                    end
                end
            end
        end
    end

    assign w_port_free = ~r_fu_valid | ~i_fu_stall;

    rs_oldest_select #(.DEPTH(RS_DEPTH)) u_sel0 (
        .i_ready   (w_slot_rdy),
        .i_age     (r_age),
        .i_exclude ({RS_DEPTH{1'b0}}),
        .o_grant   (w_grant0)
    );

    assign w_take0   = w_grant0 & {RS_DEPTH{w_port_free[0]}};
    assign w_take[0] = w_take0;

    // Port 1 skips only what port 0 actually takes, so it keeps issuing while port 0 stalls.
    if (ISSUE_WIDTH > 1) begin : g_port1
        logic [RS_DEPTH-1:0] w_grant1;

        rs_oldest_select #(.DEPTH(RS_DEPTH)) u_sel1 (
            .i_ready   (w_slot_rdy),
            .i_age     (r_age),
            .i_exclude (w_take0),
            .o_grant   (w_grant1)
        );

        assign w_take[1] = w_grant1 & {RS_DEPTH{w_port_free[1]}};
    end

    always_comb begin
        w_issued     = '0;
        w_sel_opcode = '0;
        w_sel_iaddr  = '0;
        w_sel_insn   = '0;
        w_sel_tag    = '0;
        w_sel_src    = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            w_issued = w_issued | w_take[p];
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_take[p][i]) begin
                    w_sel_opcode[p] = w_sel_opcode[p] | r_slots[i].opcode;
                    w_sel_iaddr[p]  = w_sel_iaddr[p]  | r_slots[i].iaddr;
                    w_sel_insn[p]   = w_sel_insn[p]   | r_slots[i].insn;
                    w_sel_tag[p]    = w_sel_tag[p]    | r_slots[i].dst_tag;
                    w_sel_src[p]    = w_sel_src[p]    | r_slots[i].src_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fu_valid <= '0;
        end else if (i_flush) begin
            r_fu_valid <= '0;
        end else begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                if (w_port_free[p]) begin
                    r_fu_valid[p] <= |w_take[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (|w_take[p]) begin
                r_fu_opcode[p] <= w_sel_opcode[p];
                r_fu_iaddr[p]  <= w_sel_iaddr[p];
                r_fu_insn[p]   <= w_sel_insn[p];
                r_fu_tag[p]    <= w_sel_tag[p];
                r_fu_src[p]    <= w_sel_src[p];
            end
        end
    end

    assign o_fu_valid  = r_fu_valid;
    assign o_fu_opcode = r_fu_opcode;
    assign o_fu_iaddr  = r_fu_iaddr;
    assign o_fu_insn   = r_fu_insn;
    assign o_fu_tag    = r_fu_tag;
    assign o_fu_src    = r_fu_src;

endmodule

`default_nettype wire

// File: tb/tb_reservation_station_mw.sv
// ============================================================================
// Module   : tb_reservation_station_mw
// Desc     : Directed self-checking bench for reservation_station_mw.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reservation_station_mw;
    import procyon_types::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_flush;
    logic    [1:0]       i_cdb_en;
    data_t   [1:0]       i_cdb_data;
    tag_t    [1:0]       i_cdb_tag;
    logic                i_rs_en;
    opcode_t             i_rs_opcode;
    addr_t               i_rs_iaddr;
    data_t               i_rs_insn;
    tag_t                i_rs_dst_tag;
    tag_t    [1:0]       i_rs_src_tag;
    data_t   [1:0]       i_rs_src_data;
    logic    [1:0]       i_rs_src_rdy;
    logic                o_rs_stall;
    logic    [1:0]       i_fu_stall;
    logic    [1:0]       o_fu_valid;
    opcode_t [1:0]       o_fu_opcode;
    addr_t   [1:0]       o_fu_iaddr;
    data_t   [1:0]       o_fu_insn;
    tag_t    [1:0]       o_fu_tag;
    data_t   [1:0][1:0]  o_fu_src;

    int n_tests = 0;
    int n_fail  = 0;

    reservation_station_mw #(
        .RS_DEPTH    (8),
        .NUM_SRC     (2),
        .CDB_DEPTH   (2),
        .ISSUE_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_cdb_en      (i_cdb_en),
        .i_cdb_data    (i_cdb_data),
        .i_cdb_tag     (i_cdb_tag),
        .i_rs_en       (i_rs_en),
        .i_rs_opcode   (i_rs_opcode),
        .i_rs_iaddr    (i_rs_iaddr),
        .i_rs_insn     (i_rs_insn),
        .i_rs_dst_tag  (i_rs_dst_tag),
        .i_rs_src_tag  (i_rs_src_tag),
        .i_rs_src_data (i_rs_src_data),
        .i_rs_src_rdy  (i_rs_src_rdy),
        .o_rs_stall    (o_rs_stall),
        .i_fu_stall    (i_fu_stall),
        .o_fu_valid    (o_fu_valid),
        .o_fu_opcode   (o_fu_opcode),
        .o_fu_iaddr    (o_fu_iaddr),
        .o_fu_insn     (o_fu_insn),
        .o_fu_tag      (o_fu_tag),
        .o_fu_src      (o_fu_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rs_en  = 1'b0;
        i_cdb_en = 2'b00;
    endtask

    // Opcode, address and instruction word are all derived from the destination tag.
    task automatic disp(input tag_t dst, input tag_t t0, input logic r0, input data_t d0,
                        input tag_t t1, input logic r1, input data_t d1);
        i_rs_en          = 1'b1;
        i_rs_dst_tag     = dst;
        i_rs_opcode      = dst[4:0];
        i_rs_iaddr       = 32'h1000 + {26'd0, dst};
        i_rs_insn        = 32'hA000_0000 + {26'd0, dst};
        i_rs_src_tag[0]  = t0;
        i_rs_src_rdy[0]  = r0;
        i_rs_src_data[0] = d0;
        i_rs_src_tag[1]  = t1;
        i_rs_src_rdy[1]  = r1;
        i_rs_src_data[1] = d1;
    endtask

    task automatic cdb_set(input int p, input tag_t t, input data_t d);
        i_cdb_en[p]   = 1'b1;
        i_cdb_tag[p]  = t;
        i_cdb_data[p] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b exp 00", o_fu_valid); end
        n_tests++;
        if (o_rs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", o_rs_stall); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL post_reset_valid: got %b exp 00", o_fu_valid); end
        n_tests++;
        if (o_rs_stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b exp 0", o_rs_stall); end
    endtask

    task automatic test_back_to_back();
        disp(6'd1, 6'd0, 1'b1, 32'h101, 6'd0, 1'b1, 32'h201);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_lat: got %b exp 00", o_fu_valid); end
        disp(6'd2, 6'd0, 1'b1, 32'h102, 6'd0, 1'b1, 32'h202);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd1) begin
            n_fail++; $display("FAIL b2b_tag1: got v=%b tag=%0d exp v=01 tag=1", o_fu_valid, o_fu_tag[0]);
        end
        n_tests++;
        if (o_fu_src[0][0] !== 32'h101 || o_fu_src[0][1] !== 32'h201) begin
            n_fail++; $display("FAIL b2b_src1: got %h %h exp 101 201", o_fu_src[0][0], o_fu_src[0][1]);
        end
        disp(6'd3, 6'd0, 1'b1, 32'h103, 6'd0, 1'b1, 32'h203);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd2) begin
            n_fail++; $display("FAIL b2b_tag2: got v=%b tag=%0d exp v=01 tag=2", o_fu_valid, o_fu_tag[0]);
        end
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd3 || o_fu_opcode[0] !== 5'd3 ||
            o_fu_iaddr[0] !== 32'h1003 || o_fu_insn[0] !== 32'hA000_0003) begin
            n_fail++; $display("FAIL b2b_tag3: got v=%b tag=%0d op=%0d ia=%h in=%h exp 01 3 3 1003 a0000003",
                               o_fu_valid, o_fu_tag[0], o_fu_opcode[0], o_fu_iaddr[0], o_fu_insn[0]);
        end
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_drain: got %b exp 00", o_fu_valid); end
    endtask

    task automatic test_dual_issue();
        disp(6'd4, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'h44);
        tick();
        disp(6'd6, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'h66);
        tick();
        idle();
        cdb_set(0, 6'd20, 32'h55);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL dual_wait: got %b exp 00", o_fu_valid); end
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b11 || o_fu_tag[0] !== 6'd4 || o_fu_tag[1] !== 6'd6) begin
            n_fail++; $display("FAIL dual_tags: got v=%b t0=%0d t1=%0d exp 11 4 6", o_fu_valid, o_fu_tag[0], o_fu_tag[1]);
        end
        n_tests++;
        if (o_fu_src[0][0] !== 32'h55 || o_fu_src[1][0] !== 32'h55 || o_fu_src[1][1] !== 32'h66) begin
            n_fail++; $display("FAIL dual_src: got %h %h %h exp 55 55 66", o_fu_src[0][0], o_fu_src[1][0], o_fu_src[1][1]);
        end
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL dual_drain: got %b exp 00", o_fu_valid); end
    endtask

    task automatic test_wakeup();
        disp(6'd5, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h11);
        tick();
        idle();
        cdb_set(0, 6'd9, 32'hBEEF);
        cdb_set(1, 6'd9, 32'hDEAD);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL wake_early: got %b exp 00", o_fu_valid); end
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd5) begin
            n_fail++; $display("FAIL wake_issue: got v=%b tag=%0d exp 01 5", o_fu_valid, o_fu_tag[0]);
        end
        n_tests++;
        if (o_fu_src[0][0] !== 32'hDEAD || o_fu_src[0][1] !== 32'h11) begin
            n_fail++; $display("FAIL wake_src: got %h %h exp dead 11", o_fu_src[0][0], o_fu_src[0][1]);
        end
        tick();
    endtask

    task automatic test_bypass();
        disp(6'd8, 6'd7, 1'b0, 32'h0, 6'd7, 1'b1, 32'h77);
        cdb_set(1, 6'd7, 32'h1234);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL byp_early: got %b exp 00", o_fu_valid); end
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd8) begin
            n_fail++; $display("FAIL byp_issue: got v=%b tag=%0d exp 01 8", o_fu_valid, o_fu_tag[0]);
        end
        n_tests++;
        if (o_fu_src[0][0] !== 32'h1234 || o_fu_src[0][1] !== 32'h77) begin
            n_fail++; $display("FAIL byp_src: got %h %h exp 1234 77", o_fu_src[0][0], o_fu_src[0][1]);
        end
        tick();
    endtask

    task automatic test_fu_stall();
        i_fu_stall = 2'b01;
        disp(6'd21, 6'd0, 1'b1, 32'h21, 6'd0, 1'b1, 32'h0);
        tick();
        disp(6'd22, 6'd0, 1'b1, 32'h22, 6'd0, 1'b1, 32'h0);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd21) begin
            n_fail++; $display("FAIL fst_first: got v=%b t0=%0d exp 01 21", o_fu_valid, o_fu_tag[0]);
        end
        disp(6'd23, 6'd0, 1'b1, 32'h23, 6'd0, 1'b1, 32'h0);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b11 || o_fu_tag[0] !== 6'd21 || o_fu_tag[1] !== 6'd22) begin
            n_fail++; $display("FAIL fst_p1a: got v=%b t0=%0d t1=%0d exp 11 21 22", o_fu_valid, o_fu_tag[0], o_fu_tag[1]);
        end
        disp(6'd24, 6'd0, 1'b1, 32'h24, 6'd0, 1'b1, 32'h0);
        tick();
        n_tests++;
        if (o_fu_tag[0] !== 6'd21 || o_fu_tag[1] !== 6'd23 || o_fu_opcode[1] !== 5'd23) begin
            n_fail++; $display("FAIL fst_p1b: got t0=%0d t1=%0d op1=%0d exp 21 23 23", o_fu_tag[0], o_fu_tag[1], o_fu_opcode[1]);
        end
        idle();
        i_fu_stall = 2'b11;
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b11 || o_fu_tag[0] !== 6'd21 || o_fu_tag[1] !== 6'd23) begin
            n_fail++; $display("FAIL fst_hold: got v=%b t0=%0d t1=%0d exp 11 21 23", o_fu_valid, o_fu_tag[0], o_fu_tag[1]);
        end
        n_tests++;
        if (o_fu_opcode[0] !== 5'd21 || o_fu_iaddr[0] !== 32'h1015 || o_fu_insn[0] !== 32'hA000_0015 ||
            o_fu_src[0][0] !== 32'h21) begin
            n_fail++; $display("FAIL fst_fields: got op=%0d ia=%h in=%h s=%h exp 21 1015 a0000015 21",
                               o_fu_opcode[0], o_fu_iaddr[0], o_fu_insn[0], o_fu_src[0][0]);
        end
        i_fu_stall = 2'b00;
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd24) begin
            n_fail++; $display("FAIL fst_release: got v=%b t0=%0d exp 01 24", o_fu_valid, o_fu_tag[0]);
        end
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL fst_drain: got %b exp 00", o_fu_valid); end
    endtask

    task automatic test_stall_full();
        for (int k = 0; k < 8; k++) begin
            disp(tag_t'(10 + k), tag_t'(40 + k), 1'b0, 32'h0, 6'd0, 1'b1, 32'h1);
            tick();
        end
        n_tests++;
        if (o_rs_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b exp 1", o_rs_stall); end
        disp(6'd18, 6'd0, 1'b1, 32'h18, 6'd0, 1'b1, 32'h18);
        tick();
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00 || o_rs_stall !== 1'b1) begin
            n_fail++; $display("FAIL full_ignore: got v=%b stall=%b exp 00 1", o_fu_valid, o_rs_stall);
        end
        cdb_set(0, 6'd43, 32'h4343);
        tick();
        n_tests++;
        if (o_rs_stall !== 1'b1 || o_fu_valid !== 2'b00) begin
            n_fail++; $display("FAIL full_woken: got stall=%b v=%b exp 1 00", o_rs_stall, o_fu_valid);
        end
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd13 || o_fu_src[0][0] !== 32'h4343) begin
            n_fail++; $display("FAIL full_issue: got v=%b t0=%0d s=%h exp 01 13 4343", o_fu_valid, o_fu_tag[0], o_fu_src[0][0]);
        end
        n_tests++;
        if (o_rs_stall !== 1'b0) begin n_fail++; $display("FAIL full_unstall: got %b exp 0", o_rs_stall); end
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL full_drain: got %b exp 00", o_fu_valid); end
    endtask

    task automatic test_flush();
        cdb_set(0, 6'd41, 32'h4141);
        tick();
        idle();
        cdb_set(0, 6'd40, 32'h4040);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd11) begin
            n_fail++; $display("FAIL flush_pre: got v=%b t0=%0d exp 01 11", o_fu_valid, o_fu_tag[0]);
        end
        idle();
        i_flush = 1'b1;
        disp(6'd19, 6'd0, 1'b1, 32'h19, 6'd0, 1'b1, 32'h19);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00 || o_rs_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got v=%b stall=%b exp 00 0", o_fu_valid, o_rs_stall);
        end
        i_flush = 1'b0;
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL flush_noissue: got %b exp 00", o_fu_valid); end
        cdb_set(0, 6'd42, 32'h4242);
        cdb_set(1, 6'd44, 32'h4444);
        tick();
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL flush_empty: got %b exp 00", o_fu_valid); end
    endtask

    task automatic test_reset_mid();
        disp(6'd27, 6'd0, 1'b1, 32'h27, 6'd0, 1'b1, 32'h27);
        tick();
        disp(6'd29, 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'h29);
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b01 || o_fu_tag[0] !== 6'd27) begin
            n_fail++; $display("FAIL rmid_pre: got v=%b t0=%0d exp 01 27", o_fu_valid, o_fu_tag[0]);
        end
        idle();
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_fu_valid !== 2'b00 || o_rs_stall !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got v=%b stall=%b exp 00 0", o_fu_valid, o_rs_stall);
        end
        tick();
        rst = 1'b0;
        cdb_set(0, 6'd50, 32'h5050);
        tick();
        idle();
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_discard: got %b exp 00", o_fu_valid); end
        tick();
        n_tests++;
        if (o_fu_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_quiet: got %b exp 00", o_fu_valid); end
    endtask

    initial begin
        rst           = 1'b1;
        i_flush       = 1'b0;
        i_cdb_en      = 2'b00;
        i_cdb_data    = '0;
        i_cdb_tag     = '0;
        i_rs_en       = 1'b0;
        i_rs_opcode   = '0;
        i_rs_iaddr    = '0;
        i_rs_insn     = '0;
        i_rs_dst_tag  = '0;
        i_rs_src_tag  = '0;
        i_rs_src_data = '0;
        i_rs_src_rdy  = '0;
        i_fu_stall    = 2'b00;

        test_reset();
        test_back_to_back();
        test_dual_issue();
        test_wakeup();
        test_bypass();
        test_fu_stall();
        test_stall_full();
        test_flush();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
